// File: rtl/mem_port.sv
// mem_port
// CPU-facing memory port with a 256 x 32 RAM, a 4-entry transmit FIFO that
// drains to an IO consumer, and a status register reporting FIFO state.
//
// Ports
//   clock       sole clock, rising edge
//   reset       asynchronous, active-high reset
//   address     CPU word address
//   datai       CPU write data
//   rw          1 = read cycle, 0 = write cycle
//   wr_valid    qualifies a write cycle
//   data        registered read data (1-cycle latency)
//   io_data     FIFO head word
//   io_valid    FIFO non-empty
//   io_ready    consumer accepts the head word
//   fifo_full   FIFO holds 4 words
//   fifo_count  FIFO occupancy 0..4
//   ovf         sticky overflow flag, cleared by a STATUS read
//
// Address map
//   0x000-0x0FF RAM, 0x100 TXFIFO (write-only), 0x101 STATUS (read-only),
//   everything else unmapped (reads 0, writes dropped).
module mem_port (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] datai,
  input  logic        rw,
  input  logic        wr_valid,
  output logic [31:0] data,
  output logic [31:0] io_data,
  output logic        io_valid,
  input  logic        io_ready,
  output logic        fifo_full,
  output logic [2:0]  fifo_count,
  output logic        ovf
);

  logic [31:0] r_mem [256];
  logic [31:0] r_fifoMem [4];
  logic [1:0]  r_wrPtr;
  logic [1:0]  r_rdPtr;
  logic [2:0]  r_count;
  logic        r_ovf;
  logic [31:0] r_data;

  logic        w_selRam;
  logic        w_selFifo;
  logic        w_selStatus;
  logic        w_wrEn;
  logic        w_fifoWr;
  logic        w_full;
  logic        w_ioValid;
  logic        w_pop;
  logic        w_push;
  logic        w_overflow;
  logic        w_statusRd;
  logic [31:0] w_rdData;

  // Address decode and the handshake terms that drive every state update.
  // A full FIFO still accepts a push when the head leaves on the same edge,
  // so the freed slot is reused instead of reporting an overflow.
  always_comb begin
    w_selRam    = (address[31:8] == 24'd0);
    w_selFifo   = (address == 32'h0000_0100);
    w_selStatus = (address == 32'h0000_0101);
    w_wrEn      = !rw && wr_valid;
    w_fifoWr    = w_wrEn && w_selFifo;
    w_full      = (r_count == 3'd4);
    w_ioValid   = (r_count != 3'd0);
    w_pop       = w_ioValid && io_ready;
    w_push      = w_fifoWr && (!w_full || w_pop);
    w_overflow  = w_fifoWr && w_full && !w_pop;
    w_statusRd  = rw && w_selStatus;
  end

  // Read mux; TXFIFO and unmapped addresses fall through to zero.
  always_comb begin
    w_rdData = 32'd0;
    if (w_selRam) begin
      w_rdData = r_mem[address[7:0]];
    end else if (w_selStatus) begin
      w_rdData = {27'd0, r_ovf, w_full, r_count};
    end
  end

  // RAM and FIFO storage are deliberately left out of reset; only the
  // pointers and count decide which FIFO entries are meaningful.
  always_ff @(posedge clock) begin
    if (w_wrEn && w_selRam) begin
      r_mem[address[7:0]] <= datai;
    end
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= datai;
    end
  end

  // Read data register: loads on every read cycle and holds during writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data <= 32'd0;
    end else if (rw) begin
      r_data <= w_rdData;
    end
  end

  // FIFO pointers and occupancy. Two-bit pointers wrap naturally; a
  // simultaneous push and pop moves both pointers and leaves the count alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= 2'd0;
      r_rdPtr <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 2'd1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag. A STATUS read reports the flag and clears it on the
  // same edge; a new overflow on that edge takes priority so none is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_overflow) begin
      r_ovf <= 1'b1;
    end else if (w_statusRd) begin
      r_ovf <= 1'b0;
    end
  end

  assign data       = r_data;
  assign io_data    = r_fifoMem[r_rdPtr];
  assign io_valid   = w_ioValid;
  assign fifo_full  = w_full;
  assign fifo_count = r_count;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port
// Directed testbench for mem_port: RAM access, FIFO fill/drain, overflow and
// status clearing, full push-with-pop, pointer wrap, unmapped access and an
// asynchronous reset in the middle of operation.
module tb_mem_port;

  logic        clock;
  logic        reset;
  logic [31:0] address;
  logic [31:0] datai;
  logic        rw;
  logic        wr_valid;
  logic [31:0] data;
  logic [31:0] io_data;
  logic        io_valid;
  logic        io_ready;
  logic        fifo_full;
  logic [2:0]  fifo_count;
  logic        ovf;

  int testCount = 0;
  int failCount = 0;

  mem_port dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .datai      (datai),
    .rw         (rw),
    .wr_valid   (wr_valid),
    .data       (data),
    .io_data    (io_data),
    .io_valid   (io_valid),
    .io_ready   (io_ready),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .ovf        (ovf)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs, let one rising edge consume them, then settle
  // 1 time unit past the edge so outputs are sampled away from the clock.
  task automatic applyStimulus(input logic iRw, input logic [31:0] iAddr,
                               input logic [31:0] iData, input logic iWrValid,
                               input logic iIoReady);
    rw       = iRw;
    address  = iAddr;
    datai    = iData;
    wr_valid = iWrValid;
    io_ready = iIoReady;
    @(posedge clock);
    #1;
  endtask

  // Main directed sequence.
  initial begin
    logic [31:0] expHead [4];

    reset    = 1'b1;
    rw       = 1'b0;
    address  = 32'd0;
    datai    = 32'd0;
    wr_valid = 1'b0;
    io_ready = 1'b0;

    #12;
    checkOutput("rstData",   data,              32'd0);
    checkOutput("rstCount",  {29'd0, fifo_count}, 32'd0);
    checkOutput("rstOvf",    {31'd0, ovf},       32'd0);
    checkOutput("rstValid",  {31'd0, io_valid},  32'd0);
    checkOutput("rstFull",   {31'd0, fifo_full}, 32'd0);
    reset = 1'b0;

    applyStimulus(1'b0, 32'h5, 32'hDEADBEEF, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h5, 32'h0, 1'b0, 1'b0);
    checkOutput("ramRead5", data, 32'hDEADBEEF);

    applyStimulus(1'b0, 32'h5, 32'h0, 1'b0, 1'b0);
    checkOutput("dataHold", data, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h5, 32'h0, 1'b0, 1'b0);
    checkOutput("noWrValid", data, 32'hDEADBEEF);

    applyStimulus(1'b0, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'hFF, 32'h0F0F00FF, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h200, 32'hBADBAD00, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h101, 32'hFFFFFFFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("ramRead0", data, 32'hA5A5A5A5);
    applyStimulus(1'b1, 32'hFF, 32'h0, 1'b0, 1'b0);
    checkOutput("ramReadFF", data, 32'h0F0F00FF);
    applyStimulus(1'b1, 32'h101, 32'h0, 1'b0, 1'b0);
    checkOutput("statusIdle", data, 32'h0);
    applyStimulus(1'b1, 32'h100, 32'h0, 1'b0, 1'b0);
    checkOutput("fifoRead", data, 32'h0);

    applyStimulus(1'b0, 32'h100, 32'h11, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'h22, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'h33, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'h44, 1'b1, 1'b0);
    checkOutput("fillCount", {29'd0, fifo_count}, 32'd4);
    checkOutput("fillFull",  {31'd0, fifo_full},  32'd1);
    checkOutput("fillValid", {31'd0, io_valid},   32'd1);
    checkOutput("fillHead",  io_data,             32'h11);

    expHead[0] = 32'h11; expHead[1] = 32'h22;
    expHead[2] = 32'h33; expHead[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drainHead", io_data, expHead[i]);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end
    checkOutput("drainValid", {31'd0, io_valid},   32'd0);
    checkOutput("drainCount", {29'd0, fifo_count}, 32'd0);

    applyStimulus(1'b0, 32'h100, 32'hA1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'hA2, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'hA3, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'hA4, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'h55, 1'b1, 1'b0);
    checkOutput("ovfCount", {29'd0, fifo_count}, 32'd4);
    checkOutput("ovfSet",   {31'd0, ovf},        32'd1);
    checkOutput("ovfHead",  io_data,             32'hA1);
    applyStimulus(1'b0, 32'h101, 32'h0, 1'b1, 1'b0);
    checkOutput("statusWrIgnored", {31'd0, ovf}, 32'd1);
    applyStimulus(1'b1, 32'h101, 32'h0, 1'b0, 1'b0);
    checkOutput("status1C", data, 32'h1C);
    checkOutput("ovfCleared", {31'd0, ovf}, 32'd0);
    applyStimulus(1'b1, 32'h101, 32'h0, 1'b0, 1'b0);
    checkOutput("status0C", data, 32'h0C);

    applyStimulus(1'b0, 32'h100, 32'h66, 1'b1, 1'b1);
    checkOutput("fullPushCount", {29'd0, fifo_count}, 32'd4);
    checkOutput("fullPushOvf",   {31'd0, ovf},        32'd0);
    expHead[0] = 32'hA2; expHead[1] = 32'hA3;
    expHead[2] = 32'hA4; expHead[3] = 32'h66;
    for (int i = 0; i < 4; i++) begin
      checkOutput("fullPushDrain", io_data, expHead[i]);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end
    checkOutput("fullPushEmpty", {31'd0, io_valid}, 32'd0);

    applyStimulus(1'b0, 32'h100, 32'h70, 1'b1, 1'b1);
    checkOutput("emptyReadyIgnored", {29'd0, fifo_count}, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      checkOutput("wrapHead", io_data, 32'h70 + 32'(i - 1));
      applyStimulus(1'b0, 32'h100, 32'h70 + 32'(i), 1'b1, 1'b1);
      checkOutput("wrapCount", {29'd0, fifo_count}, 32'd1);
    end
    checkOutput("wrapLast", io_data, 32'h76);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrapEmpty", {29'd0, fifo_count}, 32'd0);

    applyStimulus(1'b1, 32'h5, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1000, 32'h0, 1'b0, 1'b0);
    checkOutput("unmappedRead", data, 32'h0);

    applyStimulus(1'b0, 32'h100, 32'hB1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'hB2, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'hB3, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'hB4, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h100, 32'hB5, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("preRstCount", {29'd0, fifo_count}, 32'd2);
    checkOutput("preRstOvf",   {31'd0, ovf},        32'd1);
    checkOutput("preRstHead",  io_data,             32'hB3);
    applyStimulus(1'b1, 32'h5, 32'h0, 1'b0, 1'b0);
    checkOutput("preRstData", data, 32'hDEADBEEF);

    rw = 1'b0;
    #3 reset = 1'b1;
    #1;
    checkOutput("midRstCount", {29'd0, fifo_count}, 32'd0);
    checkOutput("midRstOvf",   {31'd0, ovf},        32'd0);
    checkOutput("midRstValid", {31'd0, io_valid},   32'd0);
    checkOutput("midRstData",  data,                32'd0);
    checkOutput("midRstFull",  {31'd0, fifo_full},  32'd0);
    #2 reset = 1'b0;

    applyStimulus(1'b0, 32'h100, 32'h88, 1'b1, 1'b0);
    checkOutput("postRstCount", {29'd0, fifo_count}, 32'd1);
    checkOutput("postRstHead",  io_data,             32'h88);
    applyStimulus(1'b1, 32'h5, 32'h0, 1'b0, 1'b0);
    checkOutput("postRstRam", data, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, named as follows.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
REQ-002 The module SHALL have the following CPU-side ports.
- address  input  32  word address from the CPU.
- datai  input  32  CPU write data.
- rw  input  1  1 = read cycle, 0 = write cycle.
- wr_valid  input  1  qualifies a write; a write occurs only when rw=0 and wr_valid=1.
- data  output  32  registered read data to the CPU.
REQ-003 The module SHALL have the following IO-side ports.
- io_data  output  32  FIFO head word.
- io_valid  output  1  FIFO non-empty.
- io_ready  input  1  consumer accepts the head word.
- fifo_full  output  1  FIFO holds 4 words.
- fifo_count  output  3  FIFO occupancy, 0 to 4.
- ovf  output  1  sticky overflow flag.

Function
REQ-004 Address map: 0x00000000-0x000000FF SHALL select RAM (256 x 32, index address[7:0]); 0x00000100 SHALL select TXFIFO; 0x00000101 SHALL select STATUS; all other addresses SHALL be unmapped.
REQ-005 RAM write: on a clock edge with rw=0, wr_valid=1 and a RAM address, mem[address[7:0]] SHALL take datai.
REQ-006 Read: on every clock edge with rw=1, data SHALL load the selected value, giving 1-cycle latency. RAM returns mem[address[7:0]]. STATUS returns {27'b0, ovf, fifo_full, fifo_count}. TXFIFO and unmapped addresses return 0.
REQ-007 Read-during-write: RAM SHALL return the old contents. Because rw selects one operation, a read and a write cannot coincide on the CPU port.
REQ-008 When rw=0, data SHALL hold its previous value.
REQ-009 Unmapped writes SHALL be ignored. STATUS writes SHALL be ignored.
REQ-010 FIFO: 4 entries, 2-bit write and read pointers that wrap 3->0, and a 3-bit count.
REQ-011 Push: a write to TXFIFO SHALL push datai when count<4, or when count=4 and a pop occurs in the same cycle.
REQ-012 Pop: a pop SHALL occur on an edge with io_valid=1 and io_ready=1; io_ready is ignored when the FIFO is empty.
REQ-013 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-014 io_valid SHALL equal (count!=0), and io_data SHALL equal the entry at the read pointer; both are combinational from registered state.
REQ-015 fifo_full SHALL equal (count==4).
REQ-016 Overflow: a TXFIFO write while full with no same-cycle pop SHALL drop the word, leave the FIFO unchanged and set ovf.
REQ-017 ovf SHALL clear on the edge that performs a STATUS read, and the returned status SHALL show ovf=1. If an overflow occurs on the same edge as the clear, set SHALL win.
REQ-018 The FIFO SHALL pass data strictly in order with no loss except overflow drops.

Reset
REQ-019 While reset=1, asynchronously: data=0, count=0, both pointers=0, ovf=0, io_valid=0, fifo_full=0.
REQ-020 io_data is don't-care after reset, and RAM contents SHALL NOT be reset.
REQ-021 Reset asserted mid-operation SHALL discard FIFO contents and any in-flight push or pop.
REQ-022 The first edge after reset deassertion SHALL behave as a normal cycle.

Verification
REQ-023 RAM write/read:
- write 0xDEADBEEF to 0x00000005;
- next cycle, read 0x00000005;
- data=0xDEADBEEF one cycle after the read edge.
REQ-024 Fill and drain:
- with io_ready=0, write 0x11, 0x22, 0x33, 0x44 to 0x100 -> fifo_count=4, fifo_full=1, io_data=0x11;
- set io_ready=1 for 4 cycles -> io_data sequence 0x11, 0x22, 0x33, 0x44, then io_valid=0 and count=0.
REQ-025 Overflow:
- with the FIFO full, write 0x55 to 0x100 with io_ready=0 -> count stays 4 and ovf=1;
- read 0x101 -> data=0x0000001C;
- next STATUS read -> data=0x0000000C.
REQ-026 Full push with pop: with the FIFO full, push 0x66 while io_ready=1 -> count stays 4, ovf stays 0, and 0x66 is drained last.
REQ-027 Wrap-around: 6 push/pop pairs, one per cycle, with the FIFO holding 1 word -> pointers wrap and the output order matches the input order.
REQ-028 Unmapped and reset mid-operation:
- read 0x00001000 -> data=0;
- assert reset asynchronously between edges with count=2 and ovf=1 -> count=0, ovf=0, io_valid=0 and data=0 immediately;
- after reset, RAM still holds 0xDEADBEEF at 0x5.
